// File: rtl/vga_fill_engine.sv
// rtl/vga_fill_engine.sv - rectangle-fill engine and write arbiter for the 80x60 VGA framebuffer
// Optional checkerboard colouring (COLOR2 register) is enabled by defining VGA_FILL_CHECKER_EN.
module vga_fill_engine #(
  parameter int unsigned FB_W         = 80,
  parameter int unsigned FB_H         = 60,
  parameter logic [7:0]  FILL_BASE_ID = 8'h94
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  PORT_ID,
  input  logic [7:0]  OUT_PORT,
  input  logic        IO_STRB,
  output logic [12:0] FB_WA,
  output logic [7:0]  FB_WD,
  output logic        FB_WE,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [7:0] ID_DIR_Y  = 8'h90;
  localparam logic [7:0] ID_DIR_X  = 8'h91;
  localparam logic [7:0] ID_DIR_WR = 8'h92;
  localparam logic [7:0] ID_X0     = FILL_BASE_ID;
  localparam logic [7:0] ID_Y0     = FILL_BASE_ID + 8'd1;
  localparam logic [7:0] ID_W      = FILL_BASE_ID + 8'd2;
  localparam logic [7:0] ID_H      = FILL_BASE_ID + 8'd3;
  localparam logic [7:0] ID_START  = FILL_BASE_ID + 8'd4;
  localparam logic [8:0] FB_W9     = 9'(FB_W);
  localparam logic [8:0] FB_H9     = 9'(FB_H);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  dir_y_q, dir_y_d;
  logic [6:0]  dir_x_q, dir_x_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [7:0]  color_q, color_d;
  logic [8:0]  sx_q, sx_d, cx_q, cx_d, cy_q, cy_d, xe_q, xe_d, ye_q, ye_d;
  logic [12:0] fb_wa_q, fb_wa_d;
  logic [7:0]  fb_wd_q, fb_wd_d;
  logic        fb_we_q, fb_we_d, busy_q, busy_d, done_q, done_d;
  logic        dir_wr, start_req, pix_vis;
  logic [7:0]  pix_color;

`ifdef VGA_FILL_CHECKER_EN
  localparam logic [7:0] ID_COLOR2 = FILL_BASE_ID + 8'd5;
  logic [7:0] color2_q, color2_d;
  assign pix_color = (cx_q[0] ^ cy_q[0]) ? color2_q : color_q;
`else
  assign pix_color = color_q;
`endif

  assign dir_wr    = IO_STRB && (PORT_ID == ID_DIR_WR);
  assign start_req = IO_STRB && (PORT_ID == ID_START);
  assign pix_vis   = (cx_q < FB_W9) && (cy_q < FB_H9);

  // Programmable registers; the fill itself only reads them at start.
  always_comb begin
    dir_y_d = dir_y_q;
    dir_x_d = dir_x_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
`ifdef VGA_FILL_CHECKER_EN
    color2_d = color2_q;
`endif
    if (IO_STRB) begin
      if (PORT_ID == ID_DIR_Y) dir_y_d = OUT_PORT[5:0];
      if (PORT_ID == ID_DIR_X) dir_x_d = OUT_PORT[6:0];
      if (PORT_ID == ID_X0)    x0_d    = OUT_PORT;
      if (PORT_ID == ID_Y0)    y0_d    = OUT_PORT;
      if (PORT_ID == ID_W)     w_d     = OUT_PORT;
      if (PORT_ID == ID_H)     h_d     = OUT_PORT;
`ifdef VGA_FILL_CHECKER_EN
      if (PORT_ID == ID_COLOR2) color2_d = OUT_PORT;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    color_d = color_q;
    sx_d    = sx_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    fb_we_d = 1'b0;
    fb_wa_d = fb_wa_q;
    fb_wd_d = fb_wd_q;
    done_d  = 1'b0;
    if (dir_wr) begin
      fb_we_d = 1'b1;
      fb_wa_d = {dir_y_q, dir_x_q};
      fb_wd_d = OUT_PORT;
    end
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if ((w_q != 8'd0) && (h_q != 8'd0)) begin
            state_d = S_FILL;
            color_d = OUT_PORT;
            sx_d    = {1'b0, x0_q};
            cx_d    = {1'b0, x0_q};
            cy_d    = {1'b0, y0_q};
            xe_d    = {1'b0, x0_q} + {1'b0, w_q} - 9'd1;
            ye_d    = {1'b0, y0_q} + {1'b0, h_q} - 9'd1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        // A direct write steals the port; the scan position simply holds.
        if (!dir_wr) begin
          fb_we_d = pix_vis;
          fb_wa_d = {cy_q[5:0], cx_q[6:0]};
          fb_wd_d = pix_color;
          if (cx_q == xe_q) begin
            cx_d = sx_q;
            if (cy_q == ye_q) state_d = S_DONE;
            else              cy_d    = cy_q + 9'd1;
          end else begin
            cx_d = cx_q + 9'd1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FILL);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      dir_y_q <= '0;
      dir_x_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      sx_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      fb_wa_q <= '0;
      fb_wd_q <= '0;
      fb_we_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef VGA_FILL_CHECKER_EN
      color2_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_y_q <= dir_y_d;
      dir_x_q <= dir_x_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      sx_q    <= sx_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      fb_wa_q <= fb_wa_d;
      fb_wd_q <= fb_wd_d;
      fb_we_q <= fb_we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef VGA_FILL_CHECKER_EN
      color2_q <= color2_d;
`endif
    end
  end

  assign FB_WA = fb_wa_q;
  assign FB_WD = fb_wd_q;
  assign FB_WE = fb_we_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule
